led_row_phy: RTL and testbench
==============================

Name: led_row_phy

Overview:
- Physical-layer serialiser for a HUB75-style RGB LED matrix panel.
- Accepts one full row pair as parallel 3-plane bit vectors: a top-half row and a bottom-half row, each with NUM_COLS columns.
- Shifts the row pair out column by column on six data lines, with a generated bit clock.
- Sits between the display controller (row/address/latch sequencing) and the panel pins; it does not drive LE/OE/address.

Parameters:
- NUM_COLS, 64, columns per row (bits shifted per transfer); must be >= 1.
- WRITE_FREQ, 25_000_000, target bit-clock frequency in Hz.
- SYS_CLK_FREQ, 100_000_000, clk_in frequency in Hz.
- Derived HALF_DIV = SYS_CLK_FREQ / (2*WRITE_FREQ), integer floor. Elaboration error if HALF_DIV < 1.

Ports:
- clk_in  input  1  system clock.
- n_reset_in  input  1  asynchronous active-low reset.
- enable_in  input  1  start request; sampled only while ready_out=1.
- col_top_in  input  [2:0][NUM_COLS-1:0]  top row; plane 0=R, 1=G, 2=B; index = column.
- col_bot_in  input  [2:0][NUM_COLS-1:0]  bottom row, same layout.
- ready_out  output  1  high when idle and able to accept enable_in.
- done_out  output  1  one-cycle pulse when a transfer completes.
- rgb_top_out  output  3  serial top data, {B,G,R}.
- rgb_bot_out  output  3  serial bottom data, {B,G,R}.
- bit_clk_out  output  1  panel shift clock; data is sampled by the panel on its rising edge.

Behaviour:
- Reset (async assert, sync-release usage assumed upstream): state IDLE; ready_out=1, done_out=0, bit_clk_out=0, rgb_top_out=0, rgb_bot_out=0; shift registers cleared.
- Reset asserted mid-transfer: abort immediately to reset values; no done_out pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready_out=1, bit_clk_out=0, rgb outputs 0.
  - On a clk_in edge k with enable_in=1: capture col_top_in and col_bot_in into internal registers, clear the bit counter, and move to SHIFT.
  - From edge k: ready_out=0, and rgb outputs present column NUM_COLS-1.
- SHIFT:
  - Each column occupies 2*HALF_DIV cycles: bit_clk_out low for HALF_DIV cycles, then high for HALF_DIV cycles.
  - rgb_top_out[p] = captured top[p][col] and rgb_bot_out[p] = captured bot[p][col], held constant for the whole column period. This gives setup and hold of HALF_DIV cycles around the rising edge.
  - Column order: NUM_COLS-1 first, down to 0 last (MSB first).
  - After the high phase of column 0, go to DONE.
- DONE (one cycle):
  - bit_clk_out=0, rgb outputs 0, done_out=1, ready_out=1.
  - Next cycle return to IDLE; done_out=0.
- Timing: the transfer is exactly NUM_COLS*2*HALF_DIV cycles after edge k. done_out and ready_out rise at edge k+NUM_COLS*2*HALF_DIV.
  - Defaults: HALF_DIV=2, so 256 cycles and 64 rising bit-clock edges.
- enable_in while ready_out=0: ignored; no queuing.
- enable_in held high continuously: a new transfer starts on the first IDLE cycle after DONE (back-to-back, one idle cycle gap).
- Input changes during SHIFT have no effect (data is captured).
- Exactly NUM_COLS rising edges of bit_clk_out per transfer; bit_clk_out never glitches and is always registered.
- Counters: phase counter clog2(HALF_DIV)+1 bits; column counter clog2(NUM_COLS)+1 bits; no wrap beyond NUM_COLS.

Decomposition:
- Package led_pkg:
  - Colour plane indices R=0, G=1, B=2.
  - Default NUM_COLS/NUM_ROWS constants.
  - typedef row_planes_t = logic [2:0][NUM_COLS-1:0].
  - State enum {IDLE, SHIFT, DONE}.
- One natural sub-module, led_bclk_gen:
  - Phase divider producing registered bit_clk_out.
  - Provides a one-cycle "advance column" strobe at the end of each high phase.
  - Enabled only in SHIFT.

Test Plan:
- Reset: hold n_reset_in=0 for 100 ns -> ready_out=1, bit_clk_out=0, rgb outputs 3'b000, done_out=0.
- Single transfer, defaults:
  - top R=64'h112233445566_7788, G=64'h99AABBCC_00000000, B=0; bottom R=64'hFFEEDDCC_BBAA9988.
  - Pulse enable_in 1 cycle.
  - Required: 64 rising edges of bit_clk_out, 4-cycle period; data sampled at each rising edge reconstructs all six vectors MSB first.
  - ready_out returns after 256 cycles, with a one-cycle done_out.
- Extremes: top all ones, bottom all zeros -> rgb_top_out=3'b111 and rgb_bot_out=3'b000 at every rising edge; rgb outputs 0 after DONE.
- Busy ignore: pulse enable_in again at cycle 50 of a transfer with changed inputs -> the original data is shifted, and only one done_out pulse occurs.
- Reset mid-transfer: assert n_reset_in at rising edge 20 -> outputs immediately return to reset values, no done_out; a subsequent transfer completes normally.
- Back-to-back: enable_in held high for two transfers -> 128 rising edges total, one idle cycle with ready_out=1 between transfers, two done_out pulses.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants and types for the HUB75 row serialiser.
package led_pkg;
  localparam int PLANE_R      = 0;
  localparam int PLANE_G      = 1;
  localparam int PLANE_B      = 2;
  localparam int NUM_PLANES   = 3;
  localparam int DEF_NUM_COLS = 64;
  localparam int DEF_NUM_ROWS = 32;

  typedef logic [NUM_PLANES-1:0][DEF_NUM_COLS-1:0] row_planes_t;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} phy_state_t;
endpackage

// File: rtl/led_row_phy_if.sv
// Controller-to-PHY bundle: start handshake, row-pair data and panel-side serial pins.
interface led_row_phy_if
  import led_pkg::*;
#(
  parameter int NUM_COLS = DEF_NUM_COLS
);
  logic                                 enable_in;
  logic [NUM_PLANES-1:0][NUM_COLS-1:0]  col_top_in;
  logic [NUM_PLANES-1:0][NUM_COLS-1:0]  col_bot_in;
  logic                                 ready_out;
  logic                                 done_out;
  logic [NUM_PLANES-1:0]                rgb_top_out;
  logic [NUM_PLANES-1:0]                rgb_bot_out;
  logic                                 bit_clk_out;

  modport master (
    output enable_in, col_top_in, col_bot_in,
    input  ready_out, done_out, rgb_top_out, rgb_bot_out, bit_clk_out
  );

  modport slave (
    input  enable_in, col_top_in, col_bot_in,
    output ready_out, done_out, rgb_top_out, rgb_bot_out, bit_clk_out
  );
endinterface

// File: rtl/led_bclk_gen.sv
// Registered bit-clock divider: low HALF_DIV cycles, high HALF_DIV cycles,
// with an advance strobe on the last cycle of each high phase.
module led_bclk_gen #(
  parameter int HALF_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bit_clk,
  output logic adv
);
  localparam int PW = $clog2(HALF_DIV) + 1;

  logic [PW-1:0] phase;
  logic          phase_end;

  assign phase_end = (phase == PW'(HALF_DIV - 1));
  assign adv       = en & bit_clk & phase_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      bit_clk <= 1'b0;
    end else if (!en) begin
      phase   <= '0;
      bit_clk <= 1'b0;
    end else if (phase_end) begin
      phase   <= '0;
      bit_clk <= ~bit_clk;
    end else begin
      phase   <= phase + 1'b1;
    end
  end
endmodule

// File: rtl/led_row_phy.sv
// HUB75 row-pair serialiser: captures top/bottom RGB planes and shifts them
// out MSB column first on six data lines alongside a divided bit clock.
module led_row_phy
  import led_pkg::*;
#(
  parameter int NUM_COLS     = DEF_NUM_COLS,
  parameter int WRITE_FREQ   = 25_000_000,
  parameter int SYS_CLK_FREQ = 100_000_000
) (
  input logic         clk_in,
  input logic         n_reset_in,
  led_row_phy_if.slave bus
);
  localparam int HALF_DIV = SYS_CLK_FREQ / (2 * WRITE_FREQ);
  localparam int CW       = $clog2(NUM_COLS) + 1;

  generate
    if (HALF_DIV < 1 || NUM_COLS < 1) begin : g_bad_cfg
      $error("led_row_phy: HALF_DIV and NUM_COLS must both be >= 1");
    end
  endgenerate

  phy_state_t                          state, nxt;
  logic [NUM_PLANES-1:0][NUM_COLS-1:0] top_sr, bot_sr;
  logic [CW-1:0]                       col_cnt;
  logic                                shifting, adv, last_col;

  assign shifting = (state == SHIFT);
  assign last_col = (col_cnt == CW'(NUM_COLS - 1));

  led_bclk_gen #(.HALF_DIV(HALF_DIV)) u_bclk (
    .clk     (clk_in),
    .rst_n   (n_reset_in),
    .en      (shifting),
    .bit_clk (bus.bit_clk_out),
    .adv     (adv)
  );

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) state <= IDLE;
    else             state <= nxt;
  end

  always_comb begin
    nxt             = state;
    bus.ready_out   = 1'b1;
    bus.done_out    = 1'b0;
    bus.rgb_top_out = '0;
    bus.rgb_bot_out = '0;
    case (state)
      IDLE:  if (bus.enable_in) nxt = SHIFT;
      SHIFT: begin
        bus.ready_out = 1'b0;
        for (int p = 0; p < NUM_PLANES; p++) begin
          bus.rgb_top_out[p] = top_sr[p][NUM_COLS-1];
          bus.rgb_bot_out[p] = bot_sr[p][NUM_COLS-1];
        end
        if (adv && last_col) nxt = DONE;
      end
      DONE: begin
        bus.done_out = 1'b1;
        nxt          = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Column N-1 always sits at the MSB; each advance strobe moves the next one up.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      top_sr  <= '0;
      bot_sr  <= '0;
      col_cnt <= '0;
    end else if (state == IDLE && bus.enable_in) begin
      top_sr  <= bus.col_top_in;
      bot_sr  <= bus.col_bot_in;
      col_cnt <= '0;
    end else if (shifting && adv) begin
      for (int p = 0; p < NUM_PLANES; p++) begin
        top_sr[p] <= top_sr[p] << 1;
        bot_sr[p] <= bot_sr[p] << 1;
      end
      col_cnt <= col_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_led_row_phy.sv
// Randomised self-checking bench for led_row_phy against a cycle-index reference model.
module tb_led_row_phy;
  import led_pkg::*;

  localparam int NC  = 64;
  localparam int WF  = 25_000_000;
  localparam int SF  = 100_000_000;
  localparam int HD  = SF / (2 * WF);
  localparam int LEN = NC * 2 * HD;

  typedef logic [2:0][NC-1:0] row_t;

  logic clk_in = 1'b0;
  logic n_reset_in;
  int   n_cmp = 0;
  int   n_err = 0;

  led_row_phy_if #(.NUM_COLS(NC)) bus ();

  led_row_phy #(
    .NUM_COLS     (NC),
    .WRITE_FREQ   (WF),
    .SYS_CLK_FREQ (SF)
  ) dut (
    .clk_in     (clk_in),
    .n_reset_in (n_reset_in),
    .bus        (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic row_t rnd_row();
    row_t r;
    for (int p = 0; p < 3; p++) r[p] = {$urandom, $urandom};
    return r;
  endfunction

  task automatic start(input row_t top, input row_t bot, input bit hold);
    @(negedge clk_in);
    bus.col_top_in = top;
    bus.col_bot_in = bot;
    bus.enable_in  = 1'b1;
    @(posedge clk_in);
    #1;
    if (!hold) bus.enable_in = 1'b0;
  endtask

  // Called just after the accepting edge; cycle c is sampled on the c-th following negedge.
  task automatic watch(input string tag, input row_t top, input row_t bot,
                       input bit poke, input int rst_edge);
    row_t       rt, rb;
    int         edges, done_at, dones, wave_err, col;
    logic       prev, eb, er, ed;
    logic [2:0] et, eo;
    bit         aborted;
    rt = '0; rb = '0;
    edges = 0; done_at = -1; dones = 0; wave_err = 0; prev = 1'b0; aborted = 1'b0;
    for (int c = 0; c <= LEN + 1 && !aborted; c++) begin
      @(negedge clk_in);
      if (c < LEN) begin
        col = NC - 1 - c / (2 * HD);
        eb  = (c % (2 * HD)) >= HD;
        er  = 1'b0;
        ed  = 1'b0;
        for (int p = 0; p < 3; p++) begin
          et[p] = top[p][col];
          eo[p] = bot[p][col];
        end
      end else begin
        eb = 1'b0; er = 1'b1; ed = (c == LEN); et = '0; eo = '0;
      end
      if (bus.bit_clk_out !== eb || bus.ready_out !== er || bus.done_out !== ed ||
          bus.rgb_top_out !== et || bus.rgb_bot_out !== eo) wave_err++;
      if (bus.done_out === 1'b1) begin
        dones++;
        if (done_at < 0) done_at = c;
      end
      if (bus.bit_clk_out === 1'b1 && prev === 1'b0) begin
        edges++;
        for (int p = 0; p < 3; p++) begin
          rt[p] = {rt[p][NC-2:0], bus.rgb_top_out[p]};
          rb[p] = {rb[p][NC-2:0], bus.rgb_bot_out[p]};
        end
      end
      prev = bus.bit_clk_out;
      if (poke && c == 50) begin
        bus.enable_in  = 1'b1;
        bus.col_top_in = ~top;
        bus.col_bot_in = ~bot;
      end
      if (poke && c == 51) bus.enable_in = 1'b0;
      if (rst_edge > 0 && edges == rst_edge) begin
        n_reset_in = 1'b0;
        #1;
        chk({tag, "/rst_ready"}, 64'(bus.ready_out), 64'd1);
        chk({tag, "/rst_bclk"},  64'(bus.bit_clk_out), 64'd0);
        chk({tag, "/rst_rgb"},   64'({bus.rgb_top_out, bus.rgb_bot_out}), 64'd0);
        repeat (3) begin
          @(negedge clk_in);
          if (bus.done_out === 1'b1) dones++;
        end
        n_reset_in = 1'b1;
        aborted    = 1'b1;
      end
    end
    if (aborted) begin
      chk({tag, "/no_done"}, 64'(dones), 64'd0);
    end else begin
      chk({tag, "/edges"},   64'(edges), 64'(NC));
      chk({tag, "/done_at"}, 64'(done_at), 64'(LEN));
      chk({tag, "/dones"},   64'(dones), 64'd1);
      chk({tag, "/wave"},    64'(wave_err), 64'd0);
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("%s/top%0d", tag, p), rt[p], top[p]);
        chk($sformatf("%s/bot%0d", tag, p), rb[p], bot[p]);
      end
    end
  endtask

  initial begin
    row_t t, b;
    n_reset_in     = 1'b0;
    bus.enable_in  = 1'b0;
    bus.col_top_in = '0;
    bus.col_bot_in = '0;
    #100;
    chk("reset/ready", 64'(bus.ready_out), 64'd1);
    chk("reset/done",  64'(bus.done_out), 64'd0);
    chk("reset/bclk",  64'(bus.bit_clk_out), 64'd0);
    chk("reset/rgb",   64'({bus.rgb_top_out, bus.rgb_bot_out}), 64'd0);
    @(negedge clk_in);
    n_reset_in = 1'b1;

    t = '0; b = '0;
    t[PLANE_R] = 64'h1122334455667788;
    t[PLANE_G] = 64'h99AABBCC00000000;
    b[PLANE_R] = 64'hFFEEDDCCBBAA9988;
    start(t, b, 1'b0);
    watch("directed", t, b, 1'b0, 0);

    t = '1; b = '0;
    start(t, b, 1'b0);
    watch("extreme", t, b, 1'b0, 0);

    for (int i = 0; i < 3; i++) begin
      t = rnd_row(); b = rnd_row();
      start(t, b, 1'b0);
      watch($sformatf("rand%0d", i), t, b, 1'b0, 0);
    end

    t = rnd_row(); b = rnd_row();
    start(t, b, 1'b0);
    watch("busy", t, b, 1'b1, 0);

    t = rnd_row(); b = rnd_row();
    start(t, b, 1'b0);
    watch("midrst", t, b, 1'b0, 20);
    t = rnd_row(); b = rnd_row();
    start(t, b, 1'b0);
    watch("after_rst", t, b, 1'b0, 0);

    t = rnd_row(); b = rnd_row();
    start(t, b, 1'b1);
    watch("b2b0", t, b, 1'b0, 0);
    @(posedge clk_in);
    #1;
    bus.enable_in = 1'b0;
    watch("b2b1", t, b, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
